// File: rtl/led_display_scroll.sv
// Multi-digit 7-segment scroller: hex characters from the UART shift into a right-aligned buffer that is scanned onto the digits.
// Optional cursor blink on the newest digit is built when LED_DISP_BLINK_EN is defined.
module led_display_scroll #(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int SCAN_HZ    = 1000,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            recv_data,
   input  logic                  recv_valid,
   output logic [NUM_DIGITS-1:0] EN,
   output logic [7:0]            SEGS
);

   localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
   localparam int CW       = $clog2(SCAN_DIV);
   localparam int IW       = $clog2(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] DIG0 = NUM_DIGITS'(1);

   typedef struct packed {
      logic       valid;
      logic       dp;
      logic [3:0] nib;
   } slot_t;

   slot_t [NUM_DIGITS-1:0] slot_q, slot_d;
   slot_t                  new_slot, cur;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic                   is_hex, is_dp, is_bs, is_esc;
   logic [3:0]             hex_val;
   logic [7:0]             glyph_q, seg_d;

   function automatic logic [7:0] glyph(input logic [3:0] h);
      case (h)
         4'h0: glyph = 8'h03;  4'h1: glyph = 8'h9F;
         4'h2: glyph = 8'h25;  4'h3: glyph = 8'h0D;
         4'h4: glyph = 8'h99;  4'h5: glyph = 8'h49;
         4'h6: glyph = 8'h41;  4'h7: glyph = 8'h1F;
         4'h8: glyph = 8'h01;  4'h9: glyph = 8'h09;
         4'hA: glyph = 8'h11;  4'hB: glyph = 8'hC1;
         4'hC: glyph = 8'h63;  4'hD: glyph = 8'h85;
         4'hE: glyph = 8'h61;  default: glyph = 8'h71;
      endcase
   endfunction

   // Letters map via low nibble + 9 ('A'/'a' low nibble is 1).
   always_comb begin
      is_hex  = 1'b0;
      hex_val = 4'h0;
      if (recv_data >= 8'h30 && recv_data <= 8'h39) begin
         is_hex  = 1'b1;
         hex_val = recv_data[3:0];
      end else if ((recv_data >= 8'h41 && recv_data <= 8'h46) ||
                   (recv_data >= 8'h61 && recv_data <= 8'h66)) begin
         is_hex  = 1'b1;
         hex_val = recv_data[3:0] + 4'd9;
      end
   end

   assign is_dp  = (recv_data == 8'h2E);
   assign is_bs  = (recv_data == 8'h08);
   assign is_esc = (recv_data == 8'h1B);
   assign new_slot = '{valid: 1'b1, dp: 1'b0, nib: hex_val};

   always_comb begin
      slot_d = slot_q;
      if (recv_valid) begin
         if (is_hex)
            slot_d = {slot_q[NUM_DIGITS-2:0], new_slot};
         else if (is_dp) begin
            if (slot_q[0].valid) slot_d[0].dp = 1'b1;
         end else if (is_bs) begin
            if (slot_q[0].valid) slot_d = {slot_t'(0), slot_q[NUM_DIGITS-1:1]};
         end else if (is_esc)
            slot_d = '0;
      end
   end

`ifdef LED_DISP_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV);
   logic [BW-1:0] blink_cnt;
   logic          blink_on;

   // Any recognised byte restarts the blink so the cursor is visible while typing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (recv_valid && (is_hex || is_dp || is_bs || is_esc)) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV-1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else
         blink_cnt <= blink_cnt + 1'b1;
   end
`endif

   assign cur     = slot_q[idx];
   assign glyph_q = glyph(cur.nib);

   always_comb begin
      seg_d = 8'hFF;
      if (cur.valid) begin
         seg_d = {glyph_q[7:1], ~cur.dp};
`ifdef LED_DISP_BLINK_EN
         if (idx == '0 && !blink_on) seg_d[4] = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         cnt    <= '0;
         idx    <= '0;
         EN     <= '1;
         SEGS   <= 8'hFF;
      end else begin
         slot_q <= slot_d;
         if (cnt == CW'(SCAN_DIV-1)) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
         end else
            cnt <= cnt + 1'b1;
         EN   <= ~(DIG0 << idx);
         SEGS <= seg_d;
      end
   end

endmodule

// File: tb/tb_led_display_scroll.sv
// Directed bench for led_display_scroll with SCAN_DIV=4, BLINK_DIV=16, 8 digits.
module tb_led_display_scroll;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] recv_data = 8'h00;
   logic       recv_valid = 1'b0;
   logic [7:0] EN, SEGS;
   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] gl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
   logic       seg_on;

   led_display_scroll #(.NUM_DIGITS(8), .CLK_FREQ(4), .SCAN_HZ(1), .BLINK_DIV(16)) dut (
      .clk(clk), .rst(rst), .recv_data(recv_data), .recv_valid(recv_valid),
      .EN(EN), .SEGS(SEGS));

   always #5 clk = ~clk;

`ifdef LED_DISP_BLINK_EN
   // Blink phase seen by the SEGS register on each edge.
   int   bcnt;
   logic bon;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt <= 0; bon <= 1'b1; seg_on <= 1'b1;
      end else begin
         seg_on <= bon;
         if (recv_valid && (recv_data inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66],
                                               8'h2E, 8'h08, 8'h1B})) begin
            bcnt <= 0; bon <= 1'b1;
         end else if (bcnt == 15) begin
            bcnt <= 0; bon <= ~bon;
         end else
            bcnt <= bcnt + 1;
      end
   end
`else
   assign seg_on = 1'b1;
`endif

   function automatic logic [7:0] exp0(input logic [7:0] g);
      return (!seg_on && g != 8'hFF) ? (g | 8'h10) : g;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      recv_data = b; recv_valid = 1'b1;
      @(negedge clk);
      recv_valid = 1'b0; recv_data = 8'h00;
   endtask

   task automatic show(input int k, input logic [7:0] exp, input string tag);
      logic [7:0] want;
      bit hit;
      want = ~(8'h01 << k);
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (EN === want) hit = 1;
      end
      if (hit) check(tag, SEGS, (k == 0) ? exp0(exp) : exp);
      else begin
         n_assert++; n_fail++;
         $display("FAIL %s: digit %0d never scanned, EN=%h", tag, k, EN);
      end
   endtask

   task automatic wait_en(input logic [7:0] want, input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < 80 && !hit; i++) begin
         @(negedge clk);
         if (EN === want) hit = 1;
      end
      if (!hit) begin
         n_assert++; n_fail++;
         $display("FAIL %s: EN never reached %h", tag, want);
      end
   endtask

   initial begin
      // 1: reset state and scan order
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_en", EN, 8'hFF);
      check("rst_segs", SEGS, 8'hFF);
      rst = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         check("scan_en", EN, ~(8'h01 << (((c - 1) / 4) % 8)));
      end

      // 2: overflow drop, '1' falls off the left
      for (int c = 1; c <= 9; c++) send(8'(8'h30 + c));
      for (int k = 0; k < 8; k++) show(k, gl[9 - k], "t2_slot");

      // 3: decimal point, repeated '.' is idempotent
      send(8'h61); send(8'h2E);
      show(0, 8'h10, "t3_dp");
      show(1, 8'h09, "t3_slot1");
      send(8'h2E);
      show(0, 8'h10, "t3_dp2");
      show(1, 8'h09, "t3_slot1b");

      // 4: backspace on empty and populated buffer
      send(8'h1B); send(8'h08);
      show(0, 8'hFF, "t4_bs_empty0");
      show(7, 8'hFF, "t4_bs_empty7");
      send(8'h33); send(8'h34); send(8'h08);
      show(0, 8'h0D, "t4_bs_slot0");
      show(1, 8'hFF, "t4_bs_slot1");

      // 5: ESC on full buffer, unrecognised bytes ignored
      for (int c = 0; c < 8; c++) send(8'(8'h30 + c));
      show(7, 8'h03, "t5_full7");
      send(8'h1B);
      show(0, 8'hFF, "t5_esc0");
      show(4, 8'hFF, "t5_esc4");
      show(7, 8'hFF, "t5_esc7");
      send(8'h47); send(8'h7A);
      show(0, 8'hFF, "t5_ign_empty");
      send(8'h35); send(8'h47);
      show(0, 8'h49, "t5_ign0");
      show(1, 8'hFF, "t5_ign1");

      // 6: byte lands on the scan-advance edge; SEGS that edge uses old slot 0
      wait_en(8'h7F, "t6_sync7");
      wait_en(8'hFE, "t6_sync0");
      @(negedge clk); @(negedge clk);
      recv_data = 8'h36; recv_valid = 1'b1;
      @(negedge clk);
      recv_valid = 1'b0; recv_data = 8'h00;
      check("t6_edge_en", EN, 8'hFE);
      check("t6_edge_segs", SEGS, exp0(8'h49));
      @(negedge clk);
      check("t6_next_en", EN, 8'hFD);
      check("t6_next_segs", SEGS, 8'h49);
      show(0, 8'h41, "t6_new0");

      // 6b: asynchronous reset mid-scan
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_en", EN, 8'hFF);
      check("t6_rst_segs", SEGS, 8'hFF);
      @(negedge clk);
      rst = 1'b0;
      show(0, 8'hFF, "t6_rst_slot0");
      show(1, 8'hFF, "t6_rst_slot1");

      // 7: slot 0 showing '8' over two full scans
      send(8'h38);
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (EN === 8'hFE) check("t7_slot0", SEGS, exp0(8'h01));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
